pc_fetch: RTL and testbench

Pipeline stage 1 of the rv64 in-order core: owns the program counter, issues one instruction-memory request at a time, and captures the returned instruction. It presents {pc, instr} to regD through the `pc_to_regD_valid` / `regD_allow_in` handshake. It also accepts a redirect from later stages, which flushes any in-flight or held fetch.

---
 rtl/pc_fetch_if.sv | 26 ++
 rtl/pc_fetch.sv | 116 +++++++++++
 tb/tb_pc_fetch.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-stage bus bundle (imem request/response, regD handshake, redirect)
interface pc_fetch_if #(
    parameter int WIDTH = 64,
    parameter int INSTR_SIZE = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [WIDTH-1:0]      imem_req_addr;
    logic                  imem_resp_valid;
    logic [INSTR_SIZE-1:0] imem_resp_data;
    logic                  regD_allow_in;
    logic                  pc_to_regD_valid;
    logic [WIDTH-1:0]      pc_to_regD_pc;
    logic [INSTR_SIZE-1:0] pc_to_regD_instr;
    logic                  redirect_valid;
    logic [WIDTH-1:0]      redirect_pc;
    logic                  fetch_misaligned;
    modport master (
        output imem_req_valid, imem_req_addr, pc_to_regD_valid, pc_to_regD_pc, pc_to_regD_instr, fetch_misaligned,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, regD_allow_in, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, pc_to_regD_valid, pc_to_regD_pc, pc_to_regD_instr, fetch_misaligned,
        output imem_req_ready, imem_resp_valid, imem_resp_data, regD_allow_in, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: PC owner / single-outstanding imem fetch / regD presenter; PC_FETCH_MISALIGN_CHECK_EN enables the misaligned-redirect FAULT path
module pc_fetch #(
    parameter int WIDTH = 64,
    parameter int INSTR_SIZE = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic       clk,
    input  logic       rst,
    pc_fetch_if.master bus
);
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
    localparam logic [INSTR_SIZE-1:0] NOP = INSTR_SIZE'(32'h0000_0013);
    logic bad;
    logic fpend, fpend_n;
    assign bad = |bus.redirect_pc[1:0];
    logic [WIDTH-1:0] tgt;
    assign tgt = bus.redirect_pc;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    logic [WIDTH-1:0] tgt;
    assign tgt = bus.redirect_pc & ~WIDTH'(3);
`endif
    state_t state, state_n;
    logic [WIDTH-1:0] pc, pc_n, req_pc, req_pc_n;
    logic [INSTR_SIZE-1:0] instr, instr_n;
    logic drop, drop_n;
    // next state: redirect wins everywhere; drop marks a response already in flight that must be discarded
    always_comb begin
        state_n = state;
        pc_n = pc;
        req_pc_n = req_pc;
        instr_n = instr;
        drop_n = drop;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        fpend_n = fpend;
`endif
        if (bus.redirect_valid) begin
            pc_n = tgt;
            case (state)
                REQ: begin
                    state_n = bus.imem_req_ready ? WAIT : REQ;
                    drop_n = bus.imem_req_ready;
                end
                WAIT: begin
                    state_n = bus.imem_resp_valid ? REQ : WAIT;
                    drop_n = !bus.imem_resp_valid;
                end
                default: state_n = REQ;
            endcase
`ifdef PC_FETCH_MISALIGN_CHECK_EN
            if (bad) begin
                state_n = FAULT;
                req_pc_n = bus.redirect_pc;
                instr_n = NOP;
                fpend_n = 1'b1;
                drop_n = 1'b0;
            end else begin
                fpend_n = 1'b0;
            end
`endif
        end else begin
            case (state)
                IDLE: state_n = REQ;
                REQ: if (bus.imem_req_ready) begin
                    state_n = WAIT;
                    req_pc_n = pc;
                    pc_n = pc + WIDTH'(4);
                end
                WAIT: if (bus.imem_resp_valid) begin
                    state_n = drop ? REQ : HOLD;
                    drop_n = 1'b0;
                    instr_n = drop ? instr : bus.imem_resp_data;
                end
                HOLD: if (bus.regD_allow_in) state_n = REQ;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
                FAULT: if (fpend && bus.regD_allow_in) fpend_n = 1'b0;
`endif
                default: state_n = IDLE;
            endcase
        end
    end
    // state, PC and the registered regD payload
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            req_pc <= '0;
            instr <= '0;
            drop <= 1'b0;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
            fpend <= 1'b0;
`endif
        end else begin
            state <= state_n;
            pc <= pc_n;
            req_pc <= req_pc_n;
            instr <= instr_n;
            drop <= drop_n;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
            fpend <= fpend_n;
`endif
        end
    end
    assign bus.imem_req_valid = state == REQ;
    assign bus.imem_req_addr = pc;
    assign bus.pc_to_regD_pc = req_pc;
    assign bus.pc_to_regD_instr = instr;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    assign bus.pc_to_regD_valid = !bus.redirect_valid && (state == HOLD || (state == FAULT && fpend));
    assign bus.fetch_misaligned = state == FAULT && fpend;
`else
    assign bus.pc_to_regD_valid = !bus.redirect_valid && state == HOLD;
    assign bus.fetch_misaligned = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch with a transaction-level fetch model and a latency-programmable imem
module tb_pc_fetch;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pc_fetch_if #(.WIDTH(64), .INSTR_SIZE(32)) bus ();
    pc_fetch #(.WIDTH(64), .INSTR_SIZE(32), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 1;
    bit mem_force = 1'b0;
    logic [31:0] mem_force_data = 32'h0;
    int mem_cnt = 0;
    logic [63:0] mem_addr = 64'h0;
    bit m_idle = 1'b1, m_pend = 1'b0, m_has = 1'b0, m_kill = 1'b0, m_fault = 1'b0, m_fpend = 1'b0;
    logic [63:0] m_addr = 64'h0, m_next = RESET_PC, m_fpc = 64'h0;
    logic [31:0] m_data = 32'h0;

    function automatic logic [31:0] data_of(logic [63:0] a);
        return a[31:0] ^ 32'h0F0F_0F0F;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_req(string name, logic [63:0] exp);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #4;
            if (bus.imem_req_valid) break;
        end
        chk(name, bus.imem_req_valid ? bus.imem_req_addr : 64'hDEAD_DEAD_DEAD_DEAD, exp);
    endtask

    // imem responder plus per-cycle model comparison, sampled 1 ns before each rising edge
    initial begin
        bit exp_req, exp_v, acc, resp;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = 32'h0;
        forever begin
            @(negedge clk);
            bus.imem_resp_valid = 1'b0;
            if (mem_cnt != 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data = mem_force ? mem_force_data : data_of(mem_addr);
                end
            end
            #4;
            if (!rst) begin
                m_idle = 1'b1; m_pend = 1'b0; m_has = 1'b0; m_kill = 1'b0;
                m_fault = 1'b0; m_fpend = 1'b0; m_next = RESET_PC;
                mem_cnt = 0;
            end else begin
                exp_req = !m_idle && !m_pend && !m_fault;
                exp_v = !bus.redirect_valid && ((m_pend && m_has) || (m_fault && m_fpend));
                chk("req_valid", bus.imem_req_valid, exp_req);
                if (exp_req) chk("req_addr", bus.imem_req_addr, m_next);
                chk("regD_valid", bus.pc_to_regD_valid, exp_v);
                if (exp_v) begin
                    chk("regD_pc", bus.pc_to_regD_pc, m_fault ? m_fpc : m_addr);
                    chk("regD_instr", bus.pc_to_regD_instr, m_fault ? 32'h13 : m_data);
                    chk("misaligned", bus.fetch_misaligned, m_fault);
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    mem_cnt = mem_lat;
                    mem_addr = bus.imem_req_addr;
                end
                acc = exp_req && bus.imem_req_ready;
                resp = bus.imem_resp_valid;
                if (bus.redirect_valid) begin
`ifdef PC_FETCH_MISALIGN_CHECK_EN
                    if (bus.redirect_pc[1:0] != 2'b00) begin
                        m_fault = 1'b1; m_fpend = 1'b1; m_fpc = bus.redirect_pc; m_pend = 1'b0;
                    end else begin
`else
                    begin
`endif
                        m_fault = 1'b0; m_fpend = 1'b0;
                        m_next = bus.redirect_pc & ~64'd3;
                        if (acc) begin
                            m_pend = 1'b1; m_has = 1'b0; m_kill = 1'b1;
                        end else if (m_pend) begin
                            if (m_has || resp) m_pend = 1'b0;
                            else m_kill = 1'b1;
                        end
                    end
                end else if (acc) begin
                    m_pend = 1'b1; m_has = 1'b0; m_kill = 1'b0;
                    m_addr = m_next;
                    m_next = m_next + 64'd4;
                end else if (m_pend && !m_has && resp) begin
                    if (m_kill) m_pend = 1'b0;
                    else begin
                        m_has = 1'b1;
                        m_data = bus.imem_resp_data;
                    end
                end else if (exp_v && bus.regD_allow_in) begin
                    if (m_fault) m_fpend = 1'b0;
                    else m_pend = 1'b0;
                end
                m_idle = 1'b0;
            end
        end
    end

    // directed stimulus with hand-computed literal expectations
    initial begin
        bus.imem_req_ready = 1'b1;
        bus.regD_allow_in = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'h0;
        #1 rst = 1'b0;
        #3;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
        chk("rst_regD_valid", bus.pc_to_regD_valid, 0);
        chk("rst_regD_pc", bus.pc_to_regD_pc, 0);
        chk("rst_regD_instr", bus.pc_to_regD_instr, 0);
        chk("rst_misaligned", bus.fetch_misaligned, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #4; chk("idle_no_req", bus.imem_req_valid, 0);
        @(negedge clk); #4;
        chk("first_req_valid", bus.imem_req_valid, 1);
        chk("first_req_addr", bus.imem_req_addr, 64'h8000_0000);
        @(negedge clk); #4; chk("wait_no_valid", bus.pc_to_regD_valid, 0);
        @(negedge clk); #4;
        chk("first_valid", bus.pc_to_regD_valid, 1);
        chk("first_pc", bus.pc_to_regD_pc, 64'h8000_0000);
        chk("first_instr", bus.pc_to_regD_instr, 64'h8F0F_0F0F);
        @(negedge clk); #4;
        chk("second_req_valid", bus.imem_req_valid, 1);
        chk("second_req_addr", bus.imem_req_addr, 64'h8000_0004);
        @(negedge clk); bus.regD_allow_in = 1'b0; #4;
        @(negedge clk); #4; chk("hold_enter", bus.pc_to_regD_valid, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #4;
            chk("hold_valid", bus.pc_to_regD_valid, 1);
            chk("hold_pc", bus.pc_to_regD_pc, 64'h8000_0004);
            chk("hold_instr", bus.pc_to_regD_instr, 64'h8F0F_0F0B);
            chk("hold_no_req", bus.imem_req_valid, 0);
        end
        @(negedge clk);
        bus.regD_allow_in = 1'b1; mem_lat = 4; mem_force = 1'b1; mem_force_data = 32'hDEAD_BEEF;
        #4; chk("hold_release_valid", bus.pc_to_regD_valid, 1);
        @(negedge clk); #4;
        chk("third_req_valid", bus.imem_req_valid, 1);
        chk("third_req_addr", bus.imem_req_addr, 64'h8000_0008);
        @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0100;
        #4; chk("wait_redir_no_req", bus.imem_req_valid, 0);
        @(negedge clk); bus.redirect_valid = 1'b0; #4;
        @(negedge clk); #4;
        @(negedge clk); #4;
        chk("dropped_resp_seen", bus.imem_resp_data, 64'hDEAD_BEEF);
        chk("dropped_no_valid", bus.pc_to_regD_valid, 0);
        @(negedge clk); mem_lat = 1; mem_force = 1'b0; #4;
        chk("redir_req_valid", bus.imem_req_valid, 1);
        chk("redir_req_addr", bus.imem_req_addr, 64'h8000_0100);
        @(negedge clk); #4;
        @(negedge clk); #4;
        chk("redir_valid", bus.pc_to_regD_valid, 1);
        chk("redir_pc", bus.pc_to_regD_pc, 64'h8000_0100);
        chk("redir_instr", bus.pc_to_regD_instr, 64'h8F0F_0E0F);
        @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0200;
        #4; chk("acc_redir_addr", bus.imem_req_addr, 64'h8000_0104);
        @(negedge clk); bus.redirect_valid = 1'b0;
        #4; chk("stale_no_valid", bus.pc_to_regD_valid, 0);
        @(negedge clk); #4;
        chk("acc_redir_req_valid", bus.imem_req_valid, 1);
        chk("acc_redir_req_addr", bus.imem_req_addr, 64'h8000_0200);
        @(negedge clk); #4;
        @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0300;
        #4; chk("hold_redir_mask", bus.pc_to_regD_valid, 0);
        @(negedge clk); bus.redirect_valid = 1'b0;
        #4; chk("hold_redir_req_addr", bus.imem_req_addr, 64'h8000_0300);
        @(negedge clk); #4;
        @(negedge clk); #4;
        chk("hold_redir_valid", bus.pc_to_regD_valid, 1);
        chk("hold_redir_pc", bus.pc_to_regD_pc, 64'h8000_0300);
        chk("hold_redir_instr", bus.pc_to_regD_instr, 64'h8F0F_0C0F);
        @(negedge clk);
        bus.imem_req_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0102;
        #4; chk("unaccepted_addr", bus.imem_req_addr, 64'h8000_0304);
        @(negedge clk); bus.imem_req_ready = 1'b1; bus.redirect_valid = 1'b0; #4;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        chk("fault_no_req", bus.imem_req_valid, 0);
        chk("fault_valid", bus.pc_to_regD_valid, 1);
        chk("fault_flag", bus.fetch_misaligned, 1);
        chk("fault_instr", bus.pc_to_regD_instr, 64'h13);
        chk("fault_pc", bus.pc_to_regD_pc, 64'h8000_0102);
        @(negedge clk); #4;
        chk("fault_done_valid", bus.pc_to_regD_valid, 0);
        chk("fault_done_no_req", bus.imem_req_valid, 0);
        @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0400; #4;
        @(negedge clk); bus.redirect_valid = 1'b0; #4;
        chk("fault_exit_addr", bus.imem_req_addr, 64'h8000_0400);
`else
        chk("misalign_req_valid", bus.imem_req_valid, 1);
        chk("misalign_req_addr", bus.imem_req_addr, 64'h8000_0100);
        chk("misalign_flag", bus.fetch_misaligned, 0);
`endif
        @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; #4;
        @(negedge clk); bus.redirect_valid = 1'b0;
        #4;
        if (!bus.imem_req_valid) next_req("wrap_top_addr", 64'hFFFF_FFFF_FFFF_FFFC);
        else chk("wrap_top_addr", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        next_req("wrap_zero_addr", 64'h0);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            bus.imem_req_ready = (i % 3) != 0;
            bus.regD_allow_in = (i % 5) != 2;
            bus.redirect_valid = (i % 13) == 7;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
            bus.redirect_pc = 64'h8000_1000 + 64'(i * 8);
`else
            bus.redirect_pc = 64'h8000_1000 + 64'(i * 8) + 64'(i % 4);
`endif
            mem_lat = 1 + i % 3;
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0; bus.imem_req_ready = 1'b1; bus.regD_allow_in = 1'b1; mem_lat = 1;
        #2 rst = 1'b0;
        #1;
        chk("arst_req_valid", bus.imem_req_valid, 0);
        chk("arst_req_addr", bus.imem_req_addr, RESET_PC);
        chk("arst_regD_valid", bus.pc_to_regD_valid, 0);
        chk("arst_regD_pc", bus.pc_to_regD_pc, 0);
        chk("arst_regD_instr", bus.pc_to_regD_instr, 0);
        chk("arst_misaligned", bus.fetch_misaligned, 0);
        @(negedge clk); rst = 1'b1;
        #4; chk("arst_idle", bus.imem_req_valid, 0);
        @(negedge clk); #4;
        chk("arst_first_req", bus.imem_req_valid, 1);
        chk("arst_first_addr", bus.imem_req_addr, RESET_PC);
        repeat (6) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
